// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file controller: opcodes, FSM states,
// accumulator source selects and the per-opcode EXEC strobe decode.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_GET   = 3'd1,
        OP_PUT   = 3'd2,
        OP_ALU   = 3'd3,
        OP_LDI   = 3'd4,
        OP_LOAD  = 3'd5,
        OP_STORE = 3'd6,
        OP_ILL   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_IMM  = 2'd2,
        SRC_MEM  = 2'd3
    } acc_src_e;

    typedef struct packed {
        logic     acc_we;
        logic     get;
        logic     put;
        logic     rdoe;
        logic     status_we;
        acc_src_e src;
    } strobes_t;

    localparam strobes_t STROBES_NONE = '{acc_we: 1'b0, get: 1'b0, put: 1'b0,
                                          rdoe: 1'b0, status_we: 1'b0, src: SRC_NONE};

    function automatic logic is_mem_op(input op_e op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Single-cycle register-file strobes for the non-memory opcodes.
    function automatic strobes_t exec_strobes(input op_e op);
        strobes_t s;
        s = STROBES_NONE;
        case (op)
            OP_GET: begin
                s.get    = 1'b1;
                s.acc_we = 1'b1;
            end
            OP_PUT: s.put = 1'b1;
            OP_ALU: begin
                s.rdoe      = 1'b1;
                s.acc_we    = 1'b1;
                s.status_we = 1'b1;
                s.src       = SRC_ALU;
            end
            OP_LDI: begin
                s.acc_we = 1'b1;
                s.src    = SRC_IMM;
            end
            default: s = STROBES_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/regfile_ctrl_mem_timeout_counter.sv
// Counts cycles spent in the MEM state; hit_o marks the last permitted cycle.
// Only instantiated when REGFILE_CTRL_MEM_TIMEOUT_EN is defined.
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic start_i,
    input  logic active_i,
    output logic hit_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hit_o = active_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Instruction sequencer driving register-file strobes and a data-memory handshake.
// Optional MEM-state timeout is enabled by defining REGFILE_CTRL_MEM_TIMEOUT_EN.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [2:0]                instr_op,
    input  logic [REG_ADDR_WIDTH-1:0] instr_reg,
    input  logic [DATA_W-1:0]         instr_imm,
    output logic                      instr_done,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic                      acc_write_enable,
    output logic                      read_get_to_acc,
    output logic                      write_put_acc,
    output logic                      read_data_output_enable,
    output logic                      status_write_enable,
    output logic [1:0]                acc_src_sel,
    output logic [DATA_W-1:0]         imm_data,
    output logic                      mem_req,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic                      err_illegal,
    output logic                      err_timeout,
    input  logic                      err_clear
);

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_e                    state_q, state_d;
    op_e                       op_q;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q;
    logic [DATA_W-1:0]         imm_q;
    logic                      err_ill_q, err_ill_d;
    logic                      accept;
    logic                      timeout_hit;
    logic                      timeout_fire;
    strobes_t                  strobes;

    assign accept = instr_valid && instr_ready;

`ifdef REGFILE_CTRL_MEM_TIMEOUT_EN
    logic err_to_q, err_to_d;

    mem_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timeout_counter (
        .clk     (clk),
        .srst    (reset),
        .start_i (accept && is_mem_op(op_e'(instr_op))),
        .active_i(state_q == ST_MEM),
        .hit_o   (timeout_hit)
    );

    // An ack on the final allowed cycle still completes the transfer normally.
    assign timeout_fire = (state_q == ST_MEM) && timeout_hit && !mem_ack;
    assign err_to_d     = timeout_fire || (err_to_q && !err_clear);
    assign err_timeout  = err_to_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_to_q <= 1'b0;
        end else begin
            err_to_q <= err_to_d;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_fire = timeout_hit;
    assign err_timeout  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched instruction fields and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_NOP;
            reg_addr_q <= '0;
            imm_q      <= '0;
            err_ill_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op_e'(instr_op);
                reg_addr_q <= instr_reg;
                imm_q      <= instr_imm;
            end
            err_ill_q <= err_ill_d;
        end
    end

    // A set in the same cycle as err_clear takes priority.
    assign err_ill_d = ((state_q == ST_EXEC) && (op_q == OP_ILL)) || (err_ill_q && !err_clear);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mem_op(op_e'(instr_op)) ? ST_MEM : ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            ST_MEM: begin
                if (mem_ack || timeout_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        strobes     = STROBES_NONE;
        instr_ready = 1'b0;
        instr_done  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: instr_ready = 1'b1;
            ST_EXEC: begin
                strobes    = exec_strobes(op_q);
                instr_done = 1'b1;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ack) begin
                    instr_done = 1'b1;
                    if (op_q == OP_LOAD) begin
                        strobes.acc_we = 1'b1;
                        strobes.src    = SRC_MEM;
                    end
                end else if (timeout_fire) begin
                    instr_done = 1'b1;
                end
            end
            default: instr_ready = 1'b0;
        endcase
    end

    assign acc_write_enable        = strobes.acc_we;
    assign read_get_to_acc         = strobes.get;
    assign write_put_acc           = strobes.put;
    assign read_data_output_enable = strobes.rdoe;
    assign status_write_enable     = strobes.status_we;
    assign acc_src_sel             = strobes.acc_we ? strobes.src : SRC_NONE;
    assign reg_addr                = reg_addr_q;
    assign imm_data                = imm_q;
    assign err_illegal             = err_ill_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomized self-checking bench for regfile_ctrl against a per-cycle
// expectation model built from the instruction semantics.
module tb_regfile_ctrl;

    localparam int MEM_TO = 16;
`ifdef REGFILE_CTRL_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [3:0] instr_reg;
    logic [7:0] instr_imm;
    logic       instr_done;
    logic [3:0] reg_addr;
    logic       acc_write_enable, read_get_to_acc, write_put_acc;
    logic       read_data_output_enable, status_write_enable;
    logic [1:0] acc_src_sel;
    logic [7:0] imm_data;
    logic       mem_req, mem_we, mem_ack;
    logic       err_illegal, err_timeout, err_clear;

    always #5 clk = ~clk;

    regfile_ctrl #(
        .DATA_W        (8),
        .REG_ADDR_WIDTH(4),
        .MEM_TIMEOUT   (MEM_TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .instr_op               (instr_op),
        .instr_reg              (instr_reg),
        .instr_imm              (instr_imm),
        .instr_done             (instr_done),
        .reg_addr               (reg_addr),
        .acc_write_enable       (acc_write_enable),
        .read_get_to_acc        (read_get_to_acc),
        .write_put_acc          (write_put_acc),
        .read_data_output_enable(read_data_output_enable),
        .status_write_enable    (status_write_enable),
        .acc_src_sel            (acc_src_sel),
        .imm_data               (imm_data),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_ack                (mem_ack),
        .err_illegal            (err_illegal),
        .err_timeout            (err_timeout),
        .err_clear              (err_clear)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    logic       e_ready, e_done, e_awe, e_get, e_put, e_rdoe, e_swe, e_req, e_we;
    logic [1:0] e_src;
    logic [3:0] e_addr;
    logic [7:0] e_imm;
    logic       e_ill, e_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_exp(input logic ready, input logic done, input logic awe, input logic get,
                           input logic put, input logic rdoe, input logic swe, input logic [1:0] src,
                           input logic req, input logic we);
        e_ready = ready; e_done = done; e_awe = awe; e_get = get; e_put = put;
        e_rdoe = rdoe; e_swe = swe; e_src = src; e_req = req; e_we = we;
    endtask

    task automatic idle_exp();
        set_exp(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    endtask

    // Check one cycle mid-period, then advance the flag model across the edge.
    task automatic step(input bit set_ill, input bit set_to, input bit clr);
        err_clear = clr;
        #1;
        check("instr_ready", instr_ready, e_ready);
        check("instr_done", instr_done, e_done);
        check("acc_write_enable", acc_write_enable, e_awe);
        check("read_get_to_acc", read_get_to_acc, e_get);
        check("write_put_acc", write_put_acc, e_put);
        check("read_data_output_enable", read_data_output_enable, e_rdoe);
        check("status_write_enable", status_write_enable, e_swe);
        check("acc_src_sel", acc_src_sel, e_src);
        check("mem_req", mem_req, e_req);
        check("mem_we", mem_we, e_we);
        check("reg_addr", reg_addr, e_addr);
        check("imm_data", imm_data, e_imm);
        check("err_illegal", err_illegal, e_ill);
        check("err_timeout", err_timeout, e_to);
        @(posedge clk);
        if (reset) begin
            e_ill = 1'b0;
            e_to  = 1'b0;
        end else begin
            e_ill = set_ill || (e_ill && !clr);
            e_to  = (TO_EN && set_to) || (e_to && !clr);
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] r, input logic [7:0] imm,
                         input int waits, input bit may_clr);
        bit clr, ack, tout;
        $display("txn op=%0d reg=%0d imm=%02h waits=%0d", op, r, imm, waits);
        idle_exp();
        instr_valid = 1'b1;
        instr_op    = op;
        instr_reg   = r;
        instr_imm   = imm;
        mem_ack     = 1'($urandom_range(0, 1));
        clr = may_clr && ($urandom_range(0, 3) == 0);
        step(0, 0, clr);
        e_addr = r;
        e_imm  = imm;
        // Offers while busy must be ignored.
        instr_valid = 1'($urandom_range(0, 1));
        instr_op    = 3'($urandom);
        instr_reg   = 4'($urandom);
        instr_imm   = 8'($urandom);
        if (op == 3'd5 || op == 3'd6) begin
            for (int i = 0; i <= waits; i++) begin
                ack  = (i == waits);
                tout = TO_EN && !ack && (i == MEM_TO - 1);
                mem_ack = ack;
                set_exp(0, ack || tout, ack && op == 3'd5, 0, 0, 0, 0,
                        (ack && op == 3'd5) ? 2'd3 : 2'd0, 1, op == 3'd6);
                clr = may_clr && ($urandom_range(0, 7) == 0);
                step(0, tout, clr);
                if (ack || tout) break;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            case (op)
                3'd1:    set_exp(0, 1, 1, 1, 0, 0, 0, 2'd0, 0, 0);
                3'd2:    set_exp(0, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0);
                3'd3:    set_exp(0, 1, 1, 0, 0, 1, 1, 2'd1, 0, 0);
                3'd4:    set_exp(0, 1, 1, 0, 0, 0, 0, 2'd2, 0, 0);
                default: set_exp(0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0);
            endcase
            clr = may_clr && ($urandom_range(0, 3) == 0);
            step(op == 3'd7, 0, clr);
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_reg = '0; instr_imm = '0;
        mem_ack = 1'b0; err_clear = 1'b0;
        e_ill = 1'b0; e_to = 1'b0; e_addr = '0; e_imm = '0;
        @(negedge clk);
        @(negedge clk);
        idle_exp();
        step(0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0);

        issue(3'd1, 4'd3, 8'h00, 0, 0);
        issue(3'd3, 4'd5, 8'h11, 0, 0);
        issue(3'd4, 4'd2, 8'hA5, 0, 0);
        issue(3'd5, 4'd7, 8'h42, 3, 0);
        issue(3'd6, 4'd8, 8'h5A, 20, 0);
        idle_exp();
        step(0, 0, 1);
        step(0, 0, 0);
        issue(3'd7, 4'd1, 8'hFF, 0, 0);

        // Reset while a LOAD waits for its ack.
        $display("txn reset during LOAD wait");
        idle_exp();
        instr_valid = 1'b1; instr_op = 3'd5; instr_reg = 4'd9; instr_imm = 8'h3C;
        step(0, 0, 0);
        e_addr = 4'd9; e_imm = 8'h3C;
        instr_valid = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        idle_exp();
        e_addr = '0; e_imm = '0;
        step(0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4)),
                  1);
        end
        idle_exp();
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameters SHALL be DATA_W (8, accumulator/immediate width), REG_ADDR_WIDTH (4, register select width) and MEM_TIMEOUT (16, max cycles waiting for mem_ack).
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 instr_valid  in  1  instruction offered.
REQ-004 instr_ready  out  1  controller can accept an instruction.
REQ-005 instr_op  in  3  opcode (op_e).
REQ-006 instr_reg  in  REG_ADDR_WIDTH  register operand.
REQ-007 instr_imm  in  DATA_W  immediate for LDI.
REQ-008 instr_done  out  1  one-cycle pulse on instruction completion.
REQ-009 reg_addr  out  REG_ADDR_WIDTH  register select to register file.
REQ-010 acc_write_enable, read_get_to_acc, write_put_acc, read_data_output_enable, status_write_enable  out  1 each  register-file strobes.
REQ-011 acc_src_sel  out  2  accumulator bus source (acc_src_e): NONE, ALU, IMM, MEM.
REQ-012 imm_data  out  DATA_W  latched immediate.
REQ-013 mem_req  out  1; mem_we  out  1; mem_ack  in  1  data-memory handshake.
REQ-014 err_illegal  out  1  sticky illegal-opcode flag; err_timeout  out  1  sticky memory-timeout flag; err_clear  in  1  clears both flags.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, MEM; instr_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, instr_valid&instr_ready SHALL latch op, reg (to reg_addr) and imm (to imm_data); GET/PUT/ALU/LDI/NOP/illegal go to EXEC, LOAD/STORE go to MEM.
REQ-017 EXEC SHALL last exactly one cycle, assert instr_done, return to IDLE; accept at cycle N gives strobes at N+1, next accept possible at N+2.
REQ-018 EXEC GET: read_get_to_acc=1, acc_write_enable=1, acc_src_sel=NONE.
REQ-019 EXEC PUT: write_put_acc=1 only.
REQ-020 EXEC ALU: read_data_output_enable=1, acc_write_enable=1, status_write_enable=1, acc_src_sel=ALU.
REQ-021 EXEC LDI: acc_write_enable=1, acc_src_sel=IMM.
REQ-022 EXEC NOP: no strobes; illegal opcode: no strobes, err_illegal set.
REQ-023 MEM SHALL hold mem_req=1, mem_we=1 for STORE/0 for LOAD, stable until ack or timeout.
REQ-024 mem_ack in MEM SHALL in the same cycle assert instr_done and, for LOAD, acc_write_enable=1 with acc_src_sel=MEM; next state IDLE, mem_req 0.
REQ-025 mem_ack outside MEM SHALL be ignored.
REQ-026 All strobes SHALL be 0 in IDLE; acc_src_sel SHALL be NONE whenever acc_write_enable=0.
REQ-027 err_clear SHALL clear flags; a same-cycle set SHALL win over err_clear.

Reset
REQ-028 reset SHALL force IDLE, instr_ready=1 on the following cycle, all strobes/mem_req/mem_we/instr_done=0, reg_addr=0, imm_data=0, acc_src_sel=NONE, both error flags 0, timeout counter 0; reset mid-MEM SHALL drop mem_req without pulsing instr_done.

Configuration
REQ-029 With REGFILE_CTRL_MEM_TIMEOUT_EN defined, a counter SHALL count MEM cycles; on reaching MEM_TIMEOUT without mem_ack, controller SHALL drop mem_req, set err_timeout, pulse instr_done, perform no accumulator write, return to IDLE; counter resets on MEM entry.
REQ-030 Without REGFILE_CTRL_MEM_TIMEOUT_EN, MEM SHALL wait indefinitely and err_timeout SHALL be tied 0.

Structure
REQ-031 Package regfile_ctrl_pkg SHALL hold op_e (NOP=0, GET=1, PUT=2, ALU=3, LDI=4, LOAD=5, STORE=6; 7 illegal), state_e and acc_src_e (NONE=0, ALU=1, IMM=2, MEM=3).
REQ-032 Timeout counter SHALL be sub-module mem_timeout_counter (start, hit outputs), instantiated only under the macro.

Verification
REQ-033 GET reg=3 accepted cycle 10 -> cycle 11 reg_addr=3, read_get_to_acc=1, acc_write_enable=1, instr_done=1; instr_ready=1 at cycle 12.
REQ-034 ALU reg=5 -> one cycle with read_data_output_enable, acc_write_enable, status_write_enable=1, acc_src_sel=ALU; LDI imm=0xA5 -> imm_data=0xA5, acc_src_sel=IMM.
REQ-035 LOAD, mem_ack after 3 wait cycles -> mem_req=1, mem_we=0 for 4 cycles, acc_write_enable with acc_src_sel=MEM on ack cycle only.
REQ-036 STORE with no ack, macro on, MEM_TIMEOUT=16 -> mem_req drops after 16 cycles, err_timeout=1, no acc write; err_clear -> 0.
REQ-037 opcode 7 -> no strobes, err_illegal=1, instr_done pulse; reset asserted during LOAD wait -> IDLE, mem_req=0, no instr_done.
